floor_request_manager: RTL
==========================

Name: floor_request_manager

Overview:
- Counterpart to fsm_controller. Consumes its motion/door commands (moving_up, moving_down, door_open, clear_current_request).
- Produces the inputs fsm_controller expects: current_floor, floor_requests, has_request_above, has_request_below.
- Latches call-button presses and retires served requests.
- Models car position by integrating motion commands over a fixed travel time per floor.
- Flags illegal motion combinations as a sticky fault.

Parameters:
NUM_FLOORS, 10, number of served floors
FLOOR_WIDTH, 4, width of floor index; must satisfy 2^FLOOR_WIDTH >= NUM_FLOORS
TICKS_PER_FLOOR, 8, clk cycles of active motion to travel one floor; minimum 2

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
button_press  input  NUM_FLOORS  level call buttons, one bit per floor, synchronous to clk
moving_up  input  1  motor up command from fsm_controller
moving_down  input  1  motor down command from fsm_controller
door_open  input  1  door open command from fsm_controller
clear_current_request  input  1  retire request at current_floor
current_floor  output  FLOOR_WIDTH  registered car position
floor_requests  output  NUM_FLOORS  registered pending-request vector
has_request_above  output  1  any pending bit with index > current_floor
has_request_below  output  1  any pending bit with index < current_floor
at_floor  output  1  car level at current_floor (travel counter zero, state IDLE)
motion_fault  output  1  sticky illegal-motion flag

Behaviour:
- Reset values (immediate on reset=1, async):
  - current_floor=0, floor_requests=0, travel_cnt=0, state=IDLE
  - at_floor=1, motion_fault=0, has_request_above=0, has_request_below=0, button history=0
- Button edge detect:
  - A request is set on a rising edge of button_press[i] (prev=0, now=1).
  - floor_requests[i] is set at the same clk edge that samples the rise: 1-cycle latency. Held buttons do not re-trigger.
- Press suppression: a press for i==current_floor is not latched while at_floor=1 and door_open=1.
- Clear: clear_current_request=1 clears floor_requests[current_floor] at the next edge.
  - Clear has priority over a same-cycle set of the same bit.
  - Other bits set normally in the same cycle.
- has_request_above and has_request_below are combinational from registered floor_requests and current_floor; no extra latency.
- Position FSM states: IDLE, TRAVEL_UP, TRAVEL_DOWN, FAULT. travel_cnt counts 0..TICKS_PER_FLOOR-1.
- IDLE:
  - moving_up only → TRAVEL_UP, cnt=1.
  - moving_down only → TRAVEL_DOWN, cnt=1.
  - Neither → stay.
- TRAVEL_UP:
  - moving_up and cnt==TICKS_PER_FLOOR-1 → current_floor+1, cnt=0, IDLE.
  - moving_up otherwise → cnt+1.
  - moving_down only → cnt-1; if cnt was 1 → cnt=0, IDLE at same floor (reversal).
  - Neither → hold cnt and state (paused, e.g. emergency stop).
- TRAVEL_DOWN: mirror of TRAVEL_UP; the floor decrements on completion.
- at_floor=1 only in IDLE.
- Result: N consecutive moving_up cycles from IDLE advance N/TICKS_PER_FLOOR floors.
- FAULT entry (any state except FAULT):
  - moving_up and moving_down both high, or
  - moving_up in IDLE at floor NUM_FLOORS-1, or
  - moving_down in IDLE at floor 0, or
  - any motion command while door_open=1.
- FAULT behaviour: motion_fault=1; current_floor and travel_cnt frozen; request latching/clearing continue. Exit only by reset.
- Reset mid-travel: returns to floor 0 IDLE; pending requests are lost.

Optional Feature:
REQ_CANCEL_EN
- Defined: a rising edge on button_press[i] while floor_requests[i]=1 and i!=current_floor clears the bit (toggle cancel). clear_current_request priority is unchanged.
- Undefined: a re-press of a pending request has no effect.

Test Plan:
- Reset, pulse button_press[3] for 1 cycle at floor 0 → next edge floor_requests=0000001000, has_request_above=1, has_request_below=0, at_floor=1.
- Hold moving_up 24 cycles (TICKS_PER_FLOOR=8) → current_floor 1,2,3 at cycles 8,16,24; at_floor=1 for one cycle at 8 and 16, stays 1 after 24.
- At floor 3, door_open=1, clear_current_request=1 with button_press[3] rising same cycle → floor_requests[3]=0; press [1] → has_request_below=1.
- moving_up 4 cycles, idle 10, moving_up 4 → floor advances exactly once, on the 8th active cycle. Then moving_up 3, moving_down 3 → IDLE, floor unchanged.
- moving_up=moving_down=1 at floor 2 → motion_fault=1 next edge; floor stays 2 under further motion; requests still latch; reset → floor 0, fault 0.
- With REQ_CANCEL_EN: press [7] twice → bit 7 set then cleared. Without REQ_CANCEL_EN: bit 7 remains set.

Source files
------------

// File: rtl/floor_request_manager.sv
// floor_request_manager: latches hall-call presses, retires served calls, integrates motion commands into a car position, flags illegal motion.
// Latency: floor_requests/current_floor/fault update one clk after the sampling edge; has_request_above/below are combinational from registers.
// Backpressure: none, every input is sampled each cycle. Optional toggle-cancel of a pending call is enabled by defining REQ_CANCEL_EN.
module floor_request_manager #(
  parameter int NUM_FLOORS      = 10,
  parameter int FLOOR_WIDTH     = 4,
  parameter int TICKS_PER_FLOOR = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_FLOORS-1:0]  button_press,
  input  logic                   moving_up,
  input  logic                   moving_down,
  input  logic                   door_open,
  input  logic                   clear_current_request,
  output logic [FLOOR_WIDTH-1:0] current_floor,
  output logic [NUM_FLOORS-1:0]  floor_requests,
  output logic                   has_request_above,
  output logic                   has_request_below,
  output logic                   at_floor,
  output logic                   motion_fault
);

  // Travel counter only needs to reach TICKS_PER_FLOOR-1.
  localparam int CNT_W = $clog2(TICKS_PER_FLOOR);

  localparam logic [FLOOR_WIDTH-1:0] TOP_FLOOR = FLOOR_WIDTH'(NUM_FLOORS - 1);
  localparam logic [FLOOR_WIDTH-1:0] BOT_FLOOR = '0;
  localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(TICKS_PER_FLOOR - 1);
  localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]       CNT_ZERO  = '0;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    TRAVEL_UP   = 2'd1,
    TRAVEL_DOWN = 2'd2,
    FAULT       = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       travel_cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic [FLOOR_WIDTH-1:0] floor_nxt;
  logic                   fault_req;
  logic                   any_motion;

  logic [NUM_FLOORS-1:0]  button_prev;
  logic [NUM_FLOORS-1:0]  button_rise;
  logic [NUM_FLOORS-1:0]  cur_onehot;
  logic [NUM_FLOORS-1:0]  suppress_mask;
  logic [NUM_FLOORS-1:0]  press_ok;
  logic [NUM_FLOORS-1:0]  cancel_mask;
  logic [NUM_FLOORS-1:0]  clear_mask;
  logic [NUM_FLOORS-1:0]  requests_nxt;

  // The car is level with a floor only when parked; a faulted car is not
  // considered level even if it stopped between floors or at one.
  assign at_floor     = (state == IDLE) && (travel_cnt == CNT_ZERO);
  assign motion_fault = (state == FAULT);
  assign any_motion   = moving_up || moving_down;

  // ------------------------------------------------------------------
  // Request vector
  // ------------------------------------------------------------------

  // One-hot of the current floor, shared by suppression, cancel and clear.
  always_comb begin
    cur_onehot = NUM_FLOORS'(1) << current_floor;
  end

  // Rising-edge detect so a held button latches only once; a press at the
  // floor the car is parked at with doors open is already being served.
  always_comb begin
    button_rise   = button_press & ~button_prev;
    suppress_mask = (at_floor && door_open) ? cur_onehot : '0;
    press_ok      = button_rise & ~suppress_mask;
  end

`ifdef REQ_CANCEL_EN
  // A new press on an already-pending call (not the current floor) withdraws it.
  always_comb begin
    cancel_mask = press_ok & floor_requests & ~cur_onehot;
  end
`else
  // Re-pressing a pending call is harmless: it simply stays pending.
  always_comb begin
    cancel_mask = '0;
  end
`endif

  // Clear is applied last so it wins over a same-cycle press of that floor.
  always_comb begin
    clear_mask   = clear_current_request ? cur_onehot : '0;
    requests_nxt = (floor_requests | press_ok) & ~cancel_mask & ~clear_mask;
  end

  // Button history and pending-request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      button_prev    <= '0;
      floor_requests <= '0;
    end else begin
      button_prev    <= button_press;
      floor_requests <= requests_nxt;
    end
  end

  // Direction hints for the controller, straight from the registered state.
  always_comb begin
    has_request_above = 1'b0;
    has_request_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (floor_requests[i] && (i > int'(current_floor))) has_request_above = 1'b1;
      if (floor_requests[i] && (i < int'(current_floor))) has_request_below = 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Position tracking
  // ------------------------------------------------------------------

  // Illegal motion: contradictory commands, running off either end of the
  // shaft from rest, or moving with the doors open. Sticky once entered.
  always_comb begin
    fault_req = 1'b0;
    if (state != FAULT) begin
      if (moving_up && moving_down) begin
        fault_req = 1'b1;
      end
      if (any_motion && door_open) begin
        fault_req = 1'b1;
      end
      if ((state == IDLE) && moving_up && (current_floor == TOP_FLOOR)) begin
        fault_req = 1'b1;
      end
      if ((state == IDLE) && moving_down && (current_floor == BOT_FLOOR)) begin
        fault_req = 1'b1;
      end
    end
  end

  // Next-state: the counter measures progress away from the last floor in
  // the direction of travel; opposite motion winds it back toward zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = travel_cnt;
    floor_nxt = current_floor;
    unique case (state)
      IDLE: begin
        if (moving_up && !moving_down) begin
          state_nxt = TRAVEL_UP;
          cnt_nxt   = CNT_ONE;
        end else if (moving_down && !moving_up) begin
          state_nxt = TRAVEL_DOWN;
          cnt_nxt   = CNT_ONE;
        end
      end
      TRAVEL_UP: begin
        if (moving_up) begin
          if (travel_cnt == CNT_LAST) begin
            floor_nxt = current_floor + 1'b1;
            cnt_nxt   = CNT_ZERO;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = travel_cnt + 1'b1;
          end
        end else if (moving_down) begin
          if (travel_cnt == CNT_ONE) begin
            cnt_nxt   = CNT_ZERO;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = travel_cnt - 1'b1;
          end
        end
      end
      TRAVEL_DOWN: begin
        if (moving_down) begin
          if (travel_cnt == CNT_LAST) begin
            floor_nxt = current_floor - 1'b1;
            cnt_nxt   = CNT_ZERO;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = travel_cnt + 1'b1;
          end
        end else if (moving_up) begin
          if (travel_cnt == CNT_ONE) begin
            cnt_nxt   = CNT_ZERO;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = travel_cnt - 1'b1;
          end
        end
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Fault freezes position exactly where the illegal command arrived.
    if (fault_req) begin
      state_nxt = FAULT;
      cnt_nxt   = travel_cnt;
      floor_nxt = current_floor;
    end
  end

  // Position state registers; reset parks the car at the bottom floor.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      travel_cnt    <= CNT_ZERO;
      current_floor <= '0;
    end else begin
      state         <= state_nxt;
      travel_cnt    <= cnt_nxt;
      current_floor <= floor_nxt;
    end
  end

endmodule
